// File: rtl/dom_fresh_mask_gen_if.sv
// Seed and fresh-mask handshake bundle for dom_fresh_mask_gen.
// master = the mask generator, slave = the seed source / mask consumer side.
interface dom_fresh_mask_gen_if #(
  parameter int ZW = 2,
  parameter int BW = 2
);
  logic [31:0]   SeedxDI;
  logic          SeedValidxSI;
  logic          SeedReadyxSO;
  logic [ZW-1:0] Zmul1xDO;
  logic [ZW-1:0] Zmul2xDO;
  logic [ZW-1:0] Zmul3xDO;
  logic [BW-1:0] Bmul1xDO;
  logic [BW-1:0] Bmul2xDO;
  logic [BW-1:0] Bmul3xDO;
  logic          RndValidxSO;
  logic          RndReadyxSI;
  logic          ReseedReqxSO;

  modport master (
    input  SeedxDI, SeedValidxSI, RndReadyxSI,
    output SeedReadyxSO, Zmul1xDO, Zmul2xDO, Zmul3xDO,
           Bmul1xDO, Bmul2xDO, Bmul3xDO, RndValidxSO, ReseedReqxSO
  );

  modport slave (
    output SeedxDI, SeedValidxSI, RndReadyxSI,
    input  SeedReadyxSO, Zmul1xDO, Zmul2xDO, Zmul3xDO,
           Bmul1xDO, Bmul2xDO, Bmul3xDO, RndValidxSO, ReseedReqxSO
  );
endinterface

// File: rtl/dom_fresh_mask_gen.sv
// 64-bit LFSR fresh-mask source for the DOM masked S-box; one K-bit word per handshake.
// Optional reseed-interval expiry is enabled by defining FRESH_MASK_RESEED_EN.
module dom_fresh_mask_gen #(
  parameter int SHARES          = 2,
  parameter int BW              = 2,
  parameter int RESEED_INTERVAL = 1024
) (
  input logic                  ClkxCI,
  input logic                  RstxBI,
  dom_fresh_mask_gen_if.master bus
);
  localparam int ZW = SHARES * (SHARES - 1);
  localparam int K  = 3 * ZW + 3 * BW;

  if (K > 64) begin : g_k_too_wide
    $error("dom_fresh_mask_gen: K = %0d exceeds the 64-bit LFSR state", K);
  end
  if (RESEED_INTERVAL < 1) begin : g_bad_interval
    $error("dom_fresh_mask_gen: RESEED_INTERVAL must be at least 1");
  end

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEED_HI  = 2'd1,
`ifdef FRESH_MASK_RESEED_EN
    RUN      = 2'd2,
    EXPIRED  = 2'd3
`else
    RUN      = 2'd2
`endif
  } state_e;

  // K Fibonacci steps of x^64+x^63+x^61+x^60+1, unrolled into one cycle.
  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < K; i++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
    return r;
  endfunction

  state_e      state, state_nxt;
  logic [63:0] s, s_nxt;
  logic        seed_fire, word_fire;
  logic        run_nxt;

`ifdef FRESH_MASK_RESEED_EN
  localparam int CW = $clog2(RESEED_INTERVAL + 1);
  logic [CW-1:0] cnt, cnt_nxt;
`endif

  assign seed_fire        = bus.SeedValidxSI;
  assign word_fire        = (state == RUN) && bus.RndReadyxSI;
  assign bus.SeedReadyxSO = 1'b1;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
`ifdef FRESH_MASK_RESEED_EN
    cnt_nxt   = cnt;
`endif
    if (word_fire) begin
      s_nxt = lfsr_adv(s);
`ifdef FRESH_MASK_RESEED_EN
      cnt_nxt = cnt + CW'(1);
      if (cnt_nxt == CW'(RESEED_INTERVAL)) state_nxt = EXPIRED;
`endif
    end
    // A seed beat overrides the word advance for the low half and the next state.
    if (seed_fire) begin
      if (state == SEED_HI) begin
        s_nxt     = {bus.SeedxDI, s[31:0]};
        if (s_nxt == 64'h0) s_nxt = 64'h1;
        state_nxt = RUN;
`ifdef FRESH_MASK_RESEED_EN
        cnt_nxt   = '0;
`endif
      end else begin
        s_nxt[31:0] = bus.SeedxDI;
        state_nxt   = SEED_HI;
      end
    end
  end

  assign run_nxt = (state_nxt == RUN);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state            <= UNSEEDED;
      s                <= '0;
`ifdef FRESH_MASK_RESEED_EN
      cnt              <= '0;
`endif
      bus.Zmul1xDO     <= '0;
      bus.Zmul2xDO     <= '0;
      bus.Zmul3xDO     <= '0;
      bus.Bmul1xDO     <= '0;
      bus.Bmul2xDO     <= '0;
      bus.Bmul3xDO     <= '0;
      bus.RndValidxSO  <= 1'b0;
      bus.ReseedReqxSO <= 1'b1;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
`ifdef FRESH_MASK_RESEED_EN
      cnt   <= cnt_nxt;
`endif
      // Outputs are registered copies of the next word, zeroed outside RUN.
      bus.Zmul1xDO    <= run_nxt ? s_nxt[ZW-1:0]              : '0;
      bus.Zmul2xDO    <= run_nxt ? s_nxt[2*ZW-1:ZW]           : '0;
      bus.Zmul3xDO    <= run_nxt ? s_nxt[3*ZW-1:2*ZW]         : '0;
      bus.Bmul1xDO    <= run_nxt ? s_nxt[3*ZW+BW-1:3*ZW]      : '0;
      bus.Bmul2xDO    <= run_nxt ? s_nxt[3*ZW+2*BW-1:3*ZW+BW] : '0;
      bus.Bmul3xDO    <= run_nxt ? s_nxt[K-1:3*ZW+2*BW]       : '0;
      bus.RndValidxSO <= run_nxt;
`ifdef FRESH_MASK_RESEED_EN
      bus.ReseedReqxSO <= (state_nxt == UNSEEDED) || (state_nxt == EXPIRED);
`else
      bus.ReseedReqxSO <= (state_nxt == UNSEEDED);
`endif
    end
  end
endmodule

// File: tb/tb_dom_fresh_mask_gen.sv
// Self-checking bench for dom_fresh_mask_gen (SHARES=2, BW=2, K=12) against a bit-stream LFSR model.
// The expiry scenario runs only when FRESH_MASK_RESEED_EN is defined.
module tb_dom_fresh_mask_gen;
  localparam int SHARES   = 2;
  localparam int BW       = 2;
  localparam int ZW       = SHARES * (SHARES - 1);
  localparam int K        = 3 * ZW + 3 * BW;
  localparam int INTERVAL = 4;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;  // bits 63,62,60,59

  logic ClkxCI = 1'b0;
  logic RstxBI;
  int   n_checks = 0;
  int   n_errors = 0;

  dom_fresh_mask_gen_if #(.ZW(ZW), .BW(BW)) bus ();

  dom_fresh_mask_gen #(
    .SHARES(SHARES), .BW(BW), .RESEED_INTERVAL(INTERVAL)
  ) dut (
    .ClkxCI(ClkxCI),
    .RstxBI(RstxBI),
    .bus   (bus)
  );

  always #5 ClkxCI = ~ClkxCI;

  // Reference model: 0 unseeded, 1 waiting high beat, 2 running, 3 expired.
  int          m_mode;
  logic [63:0] m_s;
  int          m_words;

  function automatic logic [63:0] ref_word_advance(input logic [63:0] st);
    logic [63:0] v;
    v = st;
    repeat (K) v = (v << 1) | 64'(^(v & TAPS));
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_s = '0; m_words = 0;
  endtask

  task automatic model_edge(input logic sv, input logic [31:0] sd, input logic rdy);
    int prev;
    prev = m_mode;
    if (prev == 2 && rdy) begin
      m_s = ref_word_advance(m_s);
      m_words++;
`ifdef FRESH_MASK_RESEED_EN
      if (m_words == INTERVAL) m_mode = 3;
`endif
    end
    if (sv) begin
      if (prev == 1) begin
        m_s = {sd, m_s[31:0]};
        if (m_s == 64'h0) m_s = 64'h1;
        m_mode = 2; m_words = 0;
      end else begin
        m_s = {m_s[63:32], sd};
        m_mode = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K-1:0] dut_word();
    return {bus.Bmul3xDO, bus.Bmul2xDO, bus.Bmul1xDO, bus.Zmul3xDO, bus.Zmul2xDO, bus.Zmul1xDO};
  endfunction

  task automatic check_all(input string tag);
    logic run;
    run = (m_mode == 2);
    chk({tag, "/valid"},  64'(bus.RndValidxSO),  64'(run));
    chk({tag, "/reseed"}, 64'(bus.ReseedReqxSO), 64'(m_mode == 0 || m_mode == 3));
    chk({tag, "/sready"}, 64'(bus.SeedReadyxSO), 64'(1));
    chk({tag, "/word"},   64'(dut_word()),       run ? 64'(m_s[K-1:0]) : 64'h0);
  endtask

  task automatic step(input logic sv, input logic [31:0] sd, input logic rdy, input string tag);
    bus.SeedValidxSI = sv;
    bus.SeedxDI      = sd;
    bus.RndReadyxSI  = rdy;
    @(posedge ClkxCI);
    model_edge(sv, sd, rdy);
    @(negedge ClkxCI);
    check_all(tag);
  endtask

  initial begin
    int delivered;
    RstxBI = 1'b0;
    bus.SeedValidxSI = 1'b0;
    bus.SeedxDI      = '0;
    bus.RndReadyxSI  = 1'b0;
    model_reset();
    repeat (2) @(negedge ClkxCI);
    check_all("reset");
    RstxBI = 1'b1;

    // Unseeded: nothing offered regardless of ready.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'(i % 2), "unseeded");

    // Seed 1 / 0: first word has only Z1 = 01.
    step(1'b1, 32'h0000_0001, 1'b0, "seed1_lo");
    step(1'b1, 32'h0000_0000, 1'b0, "seed1_hi");
    chk("first_word", 64'(dut_word()), 64'h001);
    step(1'b0, 32'h0, 1'b1, "seed1_hs");

    // All-zero seed is forced to 1: same first word.
    step(1'b1, 32'h0, 1'b0, "zero_lo");
    step(1'b1, 32'h0, 1'b0, "zero_hi");
    chk("zero_seed_word", 64'(dut_word()), 64'h001);

    // Back-pressure holds the word, then a streaming burst.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, "hold");
    for (int i = 0; i < 100; i++) step(1'b0, 32'h0, 1'b1, "stream");

    // Seed beat coincident with a handshake in RUN.
    step(1'b1, 32'hCAFE_F00D, 1'b1, "coinc_lo");
    chk("coinc_valid_low", 64'(bus.RndValidxSO), 64'h0);
    step(1'b0, 32'h0, 1'b1, "coinc_wait");
    step(1'b1, 32'h1234_5678, 1'b1, "coinc_hi");
    chk("coinc_new_word", 64'(dut_word()), 64'(64'hCAFE_F00D & 64'hFFF));

    // Random mix of seeding and consumption.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)), "random");

`ifdef FRESH_MASK_RESEED_EN
    step(1'b1, $urandom, 1'b0, "exp_lo");
    step(1'b1, $urandom, 1'b0, "exp_hi");
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "exp_run");
    chk("expired_valid", 64'(bus.RndValidxSO), 64'h0);
    chk("expired_req",   64'(bus.ReseedReqxSO), 64'h1);
    step(1'b1, $urandom, 1'b0, "reseed_lo");
    step(1'b1, $urandom, 1'b0, "reseed_hi");
    delivered = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.RndValidxSO) delivered++;
      step(1'b0, 32'h0, 1'b1, "reseed_run");
    end
    chk("reseed_count", 64'(delivered), 64'(INTERVAL));
`endif

    // Asynchronous reset mid-stream.
    step(1'b1, 32'hA5A5_0F0F, 1'b0, "mid_lo");
    step(1'b1, 32'h3C3C_9999, 1'b1, "mid_hi");
    step(1'b0, 32'h0, 1'b1, "mid_run");
    #2;
    RstxBI = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge ClkxCI);
    RstxBI = 1'b1;
    step(1'b0, 32'h0, 1'b1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
